// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch controller: issues word fetches, presents them to ID, and
// absorbs one in-flight word in a skid buffer when the pipeline stalls.
module inst_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h00000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] new_pc,
    input  logic        branch_flag,
    input  logic [31:0] branch_target,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst
);

    typedef enum logic [1:0] {IDLE, REQ, HOLD, DISCARD} state_t;

    state_t      state;
    logic [31:0] pc;
    logic        skid_valid;
    logic [31:0] skid_pc;
    logic [31:0] skid_inst;

    logic        consume;
    logic        out_free;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] next_addr;

    assign consume     = if_valid && !stall;
    assign out_free    = !if_valid || consume;
    // Exception redirect beats a branch; a branch from a stalled ID is not yet real.
    assign redirect    = flush || (branch_flag && !stall);
    assign redirect_pc = (flush ? new_pc : branch_target) & 32'hFFFF_FFFC;
    assign next_addr   = mem_addr + 32'd4;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            mem_req    <= 1'b0;
            mem_addr   <= 32'h0;
            if_valid   <= 1'b0;
            if_pc      <= 32'h0;
            if_inst    <= 32'h0;
            skid_valid <= 1'b0;
            skid_pc    <= 32'h0;
            skid_inst  <= 32'h0;
        end else begin
            // NOTE: these defaults sit above the state logic on purpose; a later
            // non-blocking assignment to the same register in this block wins.
            if (consume)
                if_valid <= 1'b0;
            if (redirect) begin
                pc         <= redirect_pc;
                if_valid   <= 1'b0;
                skid_valid <= 1'b0;
            end

            unique case (state)
                IDLE: begin
                    mem_req  <= 1'b1;
                    mem_addr <= redirect ? redirect_pc : pc;
                    state    <= REQ;
                end
                REQ: begin
                    if (redirect) begin
                        // Word returning on the redirect edge is stale; refetch at once.
                        if (mem_ack)
                            mem_addr <= redirect_pc;
                        else
                            state <= DISCARD;
                    end else if (mem_ack) begin
                        pc <= next_addr;
                        if (out_free) begin
                            if_valid <= 1'b1;
                            if_pc    <= mem_addr;
                            if_inst  <= mem_rdata;
                            mem_addr <= next_addr;
                        end else begin
                            skid_valid <= 1'b1;
                            skid_pc    <= mem_addr;
                            skid_inst  <= mem_rdata;
                            mem_req    <= 1'b0;
                            state      <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (redirect) begin
                        mem_req  <= 1'b1;
                        mem_addr <= redirect_pc;
                        state    <= REQ;
                    end else if (out_free) begin
                        if (skid_valid) begin
                            if_valid   <= 1'b1;
                            if_pc      <= skid_pc;
                            if_inst    <= skid_inst;
                            skid_valid <= 1'b0;
                        end else begin
                            mem_req  <= 1'b1;
                            mem_addr <= pc;
                            state    <= REQ;
                        end
                    end
                end
                DISCARD: begin
                    // The abandoned request must complete before the bus is reused.
                    if (mem_ack) begin
                        mem_addr <= redirect ? redirect_pc : pc;
                        state    <= REQ;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Bench for inst_fetch_ctrl: a latency-randomised memory plus a program-order
// scoreboard, with directed scenarios for zero-wait, wait states, skid, redirects, wrap and reset.
module tb_inst_fetch_ctrl;

    localparam logic [31:0] RESET_PC = 32'h00000000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] new_pc = 32'h0;
    logic        branch_flag = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;

    inst_fetch_ctrl #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .new_pc(new_pc),
        .branch_flag(branch_flag), .branch_target(branch_target),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst)
    );

    always #5 clk = ~clk;

    int          n_assert = 0;
    int          n_fail = 0;
    int          n_deliv = 0;
    int          lat_min = 0;
    int          lat_max = 0;
    int          spur_mode = 0;  // ack while idle: 0 never, 1 random, 2 always
    bit          pending = 1'b0;
    int          wait_cnt = 0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] exp_pc = RESET_PC;
    logic [31:0] hold_pc = 32'h0;
    bit          hold_chk = 1'b0;
    bit          redir_chk = 1'b0;

    // Contents of instruction memory: a fixed scramble of the address.
    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    // One clock: at the falling edge drive memory, score what the coming edge consumes.
    task automatic tick();
        @(negedge clk);
        if (mem_req !== 1'b1) begin
            pending   = 1'b0;
            mem_rdata = $urandom;
            case (spur_mode)
                0:       mem_ack = 1'b0;
                1:       mem_ack = 1'($urandom_range(0, 1));
                default: mem_ack = 1'b1;
            endcase
        end else begin
            if (!pending) begin
                pending  = 1'b1;
                wait_cnt = int'($urandom_range(lat_max, lat_min));
                req_addr = mem_addr;
            end else begin
                n_assert++;
                if (mem_addr !== req_addr) begin
                    n_fail++;
                    $display("FAIL addr_stable: got %h expected %h", mem_addr, req_addr);
                end
            end
            if (wait_cnt == 0) begin
                mem_ack   = 1'b1;
                mem_rdata = word_of(mem_addr);
                pending   = 1'b0;
            end else begin
                wait_cnt--;
                mem_ack   = 1'b0;
                mem_rdata = $urandom;
            end
        end

        if (hold_chk) begin
            n_assert++;
            if (!(if_valid === 1'b1 && if_pc === hold_pc)) begin
                n_fail++;
                $display("FAIL stall_hold: got valid=%b pc=%h expected valid=1 pc=%h", if_valid, if_pc, hold_pc);
            end
        end
        if (redir_chk) begin
            n_assert++;
            if (if_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL redirect_kill: got if_valid=%b expected 0", if_valid);
            end
        end
        hold_chk  = 1'b0;
        redir_chk = 1'b0;
        if (rst) begin
            exp_pc = RESET_PC;
        end else begin
            if (if_valid === 1'b1 && !stall) begin
                n_assert++;
                if (if_pc !== exp_pc) begin
                    n_fail++;
                    $display("FAIL deliver_pc: got %h expected %h", if_pc, exp_pc);
                end
                n_assert++;
                if (if_inst !== word_of(if_pc)) begin
                    n_fail++;
                    $display("FAIL deliver_inst: got %h expected %h", if_inst, word_of(if_pc));
                end
                exp_pc = if_pc + 32'd4;
                n_deliv++;
            end
            if (flush) begin
                exp_pc    = new_pc & 32'hFFFF_FFFC;
                redir_chk = 1'b1;
            end else if (branch_flag && !stall) begin
                exp_pc    = branch_target & 32'hFFFF_FFFC;
                redir_chk = 1'b1;
            end
            hold_chk = (if_valid === 1'b1) && stall && !redir_chk;
            hold_pc  = if_pc;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; stall = 1'b0; flush = 1'b0; branch_flag = 1'b0; spur_mode = 0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; spur_mode = 2; stall = 1'b1; flush = 1'b1; new_pc = 32'h0000_0400;
        repeat (3) tick();
        n_assert++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %b expected 0", mem_req); end
        n_assert++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_mem_addr: got %h expected 0", mem_addr); end
        n_assert++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL reset_if_valid: got %b expected 0", if_valid); end
        n_assert++; if (if_pc !== 32'h0) begin n_fail++; $display("FAIL reset_if_pc: got %h expected 0", if_pc); end
        n_assert++; if (if_inst !== 32'h0) begin n_fail++; $display("FAIL reset_if_inst: got %h expected 0", if_inst); end
        rst = 1'b0; stall = 1'b0; flush = 1'b0; spur_mode = 0;
        tick();
        n_assert++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL reset_first_req: got %b expected 1", mem_req); end
        n_assert++; if (mem_addr !== RESET_PC) begin n_fail++; $display("FAIL reset_first_addr: got %h expected %h", mem_addr, RESET_PC); end
        n_assert++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL reset_idle_valid: got %b expected 0", if_valid); end
    endtask

    task automatic test_zero_wait();
        do_reset();
        lat_min = 0; lat_max = 0;
        tick();
        for (int i = 0; i < 8; i++) begin
            tick();
            n_assert++; if (if_valid !== 1'b1 || if_pc !== 32'(4 * i)) begin
                n_fail++; $display("FAIL zero_wait_pc: got valid=%b pc=%h expected valid=1 pc=%h", if_valid, if_pc, 32'(4 * i));
            end
            n_assert++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL zero_wait_req: got %b expected 1", mem_req); end
        end
    endtask

    task automatic test_wait_states();
        do_reset();
        lat_min = 3; lat_max = 3;
        tick();
        for (int r = 0; r < 3; r++) begin
            for (int k = 1; k <= 4; k++) begin
                tick();
                if (k < 4) begin
                    n_assert++; if (if_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'(4 * r)) begin
                        n_fail++; $display("FAIL wait_pending: got valid=%b req=%b addr=%h expected valid=0 req=1 addr=%h", if_valid, mem_req, mem_addr, 32'(4 * r));
                    end
                end else begin
                    n_assert++; if (if_valid !== 1'b1 || if_pc !== 32'(4 * r)) begin
                        n_fail++; $display("FAIL wait_deliver: got valid=%b pc=%h expected valid=1 pc=%h", if_valid, if_pc, 32'(4 * r));
                    end
                    n_assert++; if (mem_addr !== 32'(4 * r + 4)) begin
                        n_fail++; $display("FAIL wait_next_addr: got %h expected %h", mem_addr, 32'(4 * r + 4));
                    end
                end
            end
        end
    endtask

    task automatic test_stall_skid();
        bit found;
        do_reset();
        lat_min = 2; lat_max = 2;
        tick();
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin tick(); if (if_valid === 1'b1) found = 1'b1; end
        n_assert++; if (!found) begin n_fail++; $display("FAIL skid_first_word: got timeout expected if_valid"); end
        stall = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin tick(); if (mem_req === 1'b0) found = 1'b1; end
        n_assert++; if (!found) begin n_fail++; $display("FAIL skid_req_drop: got timeout expected mem_req=0"); end
        tick();
        tick();
        n_assert++; if (mem_req !== 1'b0 || if_valid !== 1'b1 || if_pc !== 32'h0) begin
            n_fail++; $display("FAIL skid_held: got req=%b valid=%b pc=%h expected req=0 valid=1 pc=0", mem_req, if_valid, if_pc);
        end
        stall = 1'b0;
        tick();
        n_assert++; if (if_valid !== 1'b1 || if_pc !== 32'h4 || mem_req !== 1'b0) begin
            n_fail++; $display("FAIL skid_present: got valid=%b pc=%h req=%b expected valid=1 pc=4 req=0", if_valid, if_pc, mem_req);
        end
        tick();
        n_assert++; if (if_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h8) begin
            n_fail++; $display("FAIL skid_resume: got valid=%b req=%b addr=%h expected valid=0 req=1 addr=8", if_valid, mem_req, mem_addr);
        end
    endtask

    task automatic test_branch_discard();
        bit found;
        do_reset();
        lat_min = 3; lat_max = 3;
        tick();
        tick();
        branch_flag = 1'b1; branch_target = 32'h0000_0104;
        tick();
        branch_flag = 1'b0;
        n_assert++; if (mem_req !== 1'b1 || mem_addr !== 32'h0 || if_valid !== 1'b0) begin
            n_fail++; $display("FAIL discard_hold: got req=%b addr=%h valid=%b expected req=1 addr=0 valid=0", mem_req, mem_addr, if_valid);
        end
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            tick();
            n_assert++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL discard_valid: got %b expected 0", if_valid); end
            if (mem_addr !== 32'h0) found = 1'b1;
        end
        n_assert++; if (!found || mem_addr !== 32'h0000_0104 || mem_req !== 1'b1) begin
            n_fail++; $display("FAIL discard_refetch: got req=%b addr=%h expected req=1 addr=00000104", mem_req, mem_addr);
        end
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin tick(); if (if_valid === 1'b1) found = 1'b1; end
        n_assert++; if (!found || if_pc !== 32'h0000_0104) begin
            n_fail++; $display("FAIL branch_deliver: got valid=%b pc=%h expected valid=1 pc=00000104", if_valid, if_pc);
        end
    endtask

    task automatic test_flush_priority();
        bit found;
        do_reset();
        lat_min = 2; lat_max = 2;
        tick();
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin tick(); if (if_valid === 1'b1) found = 1'b1; end
        n_assert++; if (!found) begin n_fail++; $display("FAIL flush_first_word: got timeout expected if_valid"); end
        stall = 1'b1; flush = 1'b1; new_pc = 32'h0000_0180;
        branch_flag = 1'b1; branch_target = 32'h0000_0240;
        tick();
        stall = 1'b0; flush = 1'b0; branch_flag = 1'b0;
        n_assert++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL flush_kill: got %b expected 0", if_valid); end
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            tick();
            n_assert++; if (mem_addr === 32'h0000_0240) begin n_fail++; $display("FAIL flush_branch_used: got %h expected not 00000240", mem_addr); end
            if (mem_addr === 32'h0000_0180) found = 1'b1;
        end
        n_assert++; if (!found) begin n_fail++; $display("FAIL flush_addr: got %h expected 00000180", mem_addr); end
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin tick(); if (if_valid === 1'b1) found = 1'b1; end
        n_assert++; if (!found || if_pc !== 32'h0000_0180) begin
            n_fail++; $display("FAIL flush_deliver: got valid=%b pc=%h expected valid=1 pc=00000180", if_valid, if_pc);
        end
    endtask

    task automatic test_wrap_reset();
        do_reset();
        lat_min = 0; lat_max = 0;
        tick();
        flush = 1'b1; new_pc = 32'hFFFF_FFFC;
        tick();
        flush = 1'b0;
        n_assert++; if (mem_addr !== 32'hFFFF_FFFC || mem_req !== 1'b1 || if_valid !== 1'b0) begin
            n_fail++; $display("FAIL wrap_setup: got addr=%h req=%b valid=%b expected addr=fffffffc req=1 valid=0", mem_addr, mem_req, if_valid);
        end
        tick();
        n_assert++; if (if_valid !== 1'b1 || if_pc !== 32'hFFFF_FFFC || mem_addr !== 32'h0) begin
            n_fail++; $display("FAIL wrap_addr: got valid=%b pc=%h addr=%h expected valid=1 pc=fffffffc addr=0", if_valid, if_pc, mem_addr);
        end
        lat_min = 5; lat_max = 5;
        tick();
        n_assert++; if (if_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h0) begin
            n_fail++; $display("FAIL wrap_pending: got valid=%b req=%b addr=%h expected valid=0 req=1 addr=0", if_valid, mem_req, mem_addr);
        end
        rst = 1'b1;
        tick();
        n_assert++; if (mem_req !== 1'b0 || if_valid !== 1'b0) begin
            n_fail++; $display("FAIL midreq_reset: got req=%b valid=%b expected req=0 valid=0", mem_req, if_valid);
        end
        rst = 1'b0; spur_mode = 2;
        tick();
        n_assert++; if (if_valid !== 1'b0 || mem_req !== 1'b1) begin
            n_fail++; $display("FAIL stale_ack: got valid=%b req=%b expected valid=0 req=1", if_valid, mem_req);
        end
        tick();
        n_assert++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL stale_ack_late: got %b expected 0", if_valid); end
        spur_mode = 0;
    endtask

    task automatic test_random();
        int start;
        do_reset();
        start = n_deliv;
        lat_min = 0; lat_max = 3; spur_mode = 1;
        for (int i = 0; i < 3000; i++) begin
            stall         = ($urandom_range(0, 99) < 30);
            flush         = ($urandom_range(0, 99) < 3);
            branch_flag   = ($urandom_range(0, 99) < 6);
            new_pc        = $urandom;
            branch_target = $urandom;
            rst           = ($urandom_range(0, 999) < 3);
            tick();
        end
        rst = 1'b0; stall = 1'b0; flush = 1'b0; branch_flag = 1'b0; spur_mode = 0;
        n_assert++; if (n_deliv - start < 150) begin
            n_fail++; $display("FAIL random_throughput: got %0d deliveries expected at least 150", n_deliv - start);
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_stall_skid();
        test_branch_discard();
        test_flush_priority();
        test_wrap_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
